pwm_drive: RTL and testbench

PWM_DRIVE -- requirements
Module: pwm_drive

---
 rtl/pwm_pkg.sv | 28 ++
 rtl/pwm_drive_tick_gen.sv | 34 +++
 rtl/pwm_drive.sv | 127 ++++++++++++
 tb/tb_pwm_drive.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM actuator drive: mode encoding, default
// timing parameters and the mode-request decode used at period boundaries.
package pwm_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'd0,
    MODE_HEAT = 2'd1,
    MODE_DEAD = 2'd2,
    MODE_COOL = 2'd3
  } mode_e;

  localparam int unsigned DEFAULT_PRESCALE     = 64;
  localparam int unsigned DEFAULT_DEAD_PERIODS = 4;

  // Mode requested by the PID stage: disable wins, then cooling, else heating.
  function automatic mode_e requested_mode(input logic enable, input logic neg);
    mode_e m;
    if (!enable) begin
      m = MODE_OFF;
    end else if (neg) begin
      m = MODE_COOL;
    end else begin
      m = MODE_HEAT;
    end
    return m;
  endfunction

endpackage

// File: rtl/pwm_drive_tick_gen.sv
// Free-running prescaler: counts 0..PRESCALE-1 and flags the last count as a
// one-clock tick, then wraps. Never stops, so PWM timing ignores the mode.
module tick_gen
  import pwm_pkg::*;
#(
  parameter int unsigned PRESCALE = DEFAULT_PRESCALE
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(PRESCALE - 1);

  logic [15:0] count_q;
  logic [15:0] count_d;

  assign tick = (count_q == LAST);

  // Next count: wrap to zero on the tick, otherwise advance.
  always_comb begin
    count_d = tick ? 16'd0 : count_q + 16'd1;
  end

  // Prescaler register, cleared asynchronously by reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pwm_drive.sv
// Heater/cooler actuator drive. An 8-bit phase counter stepped by the
// prescaler tick defines a 256-tick PWM period. Inputs are shadowed at each
// period boundary; the mode FSM only moves at boundaries (except disable),
// and heat/cool reversals pass through DEAD_PERIODS dead periods.
// period_start acts as a valid strobe: it is high for exactly the one clock
// on which a new period's outputs first appear, with no back-pressure.
module pwm_drive
  import pwm_pkg::*;
#(
  parameter int unsigned PRESCALE     = DEFAULT_PRESCALE,
  parameter int unsigned DEAD_PERIODS = DEFAULT_DEAD_PERIODS
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] level,
  input  logic       neg,
  input  logic       enable,
  output logic       heat_out,
  output logic       cool_out,
  output logic       period_start,
  output logic [1:0] mode
);

  localparam logic [7:0] DEAD_LOAD = 8'(DEAD_PERIODS - 1);

  logic       tick;
  logic       boundary;
  logic [7:0] phase_q, phase_d;
  logic [7:0] duty_q, duty_d;
  logic       neg_q, neg_d;
  logic [7:0] dead_cnt_q, dead_cnt_d;
  mode_e      state_q, state_d;
  mode_e      req_mode;
  logic       heat_q, heat_d;
  logic       cool_q, cool_d;
  logic       start_q;

  tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick_gen (
    .clock(clock),
    .reset(reset),
    .tick (tick)
  );

  assign boundary = tick && (phase_q == 8'd255);
  assign req_mode = requested_mode(enable, neg_d);

  // Phase advance and boundary shadowing of the PID requests.
  always_comb begin
    phase_d = tick ? phase_q + 8'd1 : phase_q;
    duty_d  = boundary ? level : duty_q;
    neg_d   = boundary ? neg : neg_q;
  end

  // Mode FSM next state: disable is immediate, all else waits for a boundary.
  always_comb begin
    state_d    = state_q;
    dead_cnt_d = dead_cnt_q;
    if (!enable) begin
      state_d = MODE_OFF;
    end else if (boundary) begin
      case (state_q)
        MODE_OFF: state_d = req_mode;
        MODE_HEAT: begin
          if (req_mode == MODE_COOL) begin
            state_d    = MODE_DEAD;
            dead_cnt_d = DEAD_LOAD;
          end else begin
            state_d = req_mode;
          end
        end
        MODE_COOL: begin
          if (req_mode == MODE_HEAT) begin
            state_d    = MODE_DEAD;
            dead_cnt_d = DEAD_LOAD;
          end else begin
            state_d = req_mode;
          end
        end
        MODE_DEAD: begin
          if (dead_cnt_q == 8'd0) begin
            state_d = req_mode;
          end else begin
            dead_cnt_d = dead_cnt_q - 8'd1;
          end
        end
        default: state_d = MODE_OFF;
      endcase
    end
  end

  // Output decode from next-state values so outputs line up with the phase register.
  always_comb begin
    heat_d = (state_d == MODE_HEAT) && (phase_d < duty_d);
    cool_d = (state_d == MODE_COOL);
  end

  // All state and registered outputs, cleared asynchronously by reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase_q    <= '0;
      duty_q     <= '0;
      neg_q      <= 1'b0;
      dead_cnt_q <= '0;
      state_q    <= MODE_OFF;
      heat_q     <= 1'b0;
      cool_q     <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      duty_q     <= duty_d;
      neg_q      <= neg_d;
      dead_cnt_q <= dead_cnt_d;
      state_q    <= state_d;
      heat_q     <= heat_d;
      cool_q     <= cool_d;
      start_q    <= boundary;
    end
  end

  assign heat_out     = heat_q;
  assign cool_out     = cool_q;
  assign period_start = start_q;
  assign mode         = state_q;

endmodule

// File: tb/tb_pwm_drive.sv
// Bench for pwm_drive with PRESCALE=4, DEAD_PERIODS=2 (1024-clock periods).
// The driver pushes one expected {heat clocks, cool clocks, mode} record per
// period; the monitor closes a period on every period_start and compares.
module tb_pwm_drive;
  import pwm_pkg::*;

  localparam int PRESCALE     = 4;
  localparam int DEAD_PERIODS = 2;
  localparam int PERIOD       = 256 * PRESCALE;
  localparam int NVEC         = 17;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] level = 8'd0;
  logic       neg = 1'b0;
  logic       enable = 1'b0;
  logic       heat_out, cool_out, period_start;
  logic [1:0] mode;

  int errors = 0;
  int checks = 0;

  logic [23:0] exp_q[$];
  logic [23:0] mon_e;
  logic        mon_en = 1'b0;
  int          heat_cnt = 0;
  int          cool_cnt = 0;
  int          per_mode = 0;
  int          per_idx = 0;

  // Table: inputs applied during period k (after t_dly clocks), expected for period k+1.
  int t_neg  [NVEC] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0};
  int t_lvl  [NVEC] = '{64, 0, 255, 128, 128, 128, 128, 128, 1, 1, 1, 200, 200, 200, 64, 200, 128};
  int t_dly  [NVEC] = '{0, 0, 0, 0, 400, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 400, 0};
  int t_heat [NVEC] = '{256, 0, 1020, 512, 0, 0, 0, 0, 0, 0, 0, 0, 0, 800, 256, 800, 512};
  int t_cool [NVEC] = '{0, 0, 0, 0, 0, 0, 1024, 1024, 0, 0, 1024, 0, 0, 0, 0, 0, 0};
  int t_mode [NVEC] = '{1, 1, 1, 1, 2, 2, 3, 3, 2, 2, 3, 2, 2, 1, 1, 1, 1};

  pwm_drive #(
    .PRESCALE    (PRESCALE),
    .DEAD_PERIODS(DEAD_PERIODS)
  ) dut (
    .clock       (clk),
    .reset       (rst_n),
    .level       (level),
    .neg         (neg),
    .enable      (enable),
    .heat_out    (heat_out),
    .cool_out    (cool_out),
    .period_start(period_start),
    .mode        (mode)
  );

  // Clock and reset block
  always #5 clk = ~clk;

  function automatic logic [23:0] pack(input int h, input int c, input int m);
    return {11'(h), 11'(c), 2'(m)};
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for period_start", name);
  endtask

  // Driver helper: wait for the next period_start, bounded.
  task automatic wait_ps(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_start && n < PERIOD + 16);
    if (!period_start) timeout_fail(name);
  endtask

  // Monitor: per-clock exclusivity/stability, per-period scoreboard compare.
  always @(negedge clk) begin
    if (!rst_n) begin
      heat_cnt = 0;
      cool_cnt = 0;
      per_mode = 0;
    end else if (mon_en) begin
      check("heat_cool_exclusive", int'(heat_out & cool_out), 0);
      if (period_start) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard: period %0d ended with empty expected queue", per_idx);
        end else begin
          mon_e = exp_q.pop_front();
          check($sformatf("period%0d_heat_clocks", per_idx), heat_cnt, int'(mon_e[23:13]));
          check($sformatf("period%0d_cool_clocks", per_idx), cool_cnt, int'(mon_e[12:2]));
          check($sformatf("period%0d_mode", per_idx), per_mode, int'(mon_e[1:0]));
        end
        per_idx++;
        heat_cnt = int'(heat_out);
        cool_cnt = int'(cool_out);
        per_mode = int'(mode);
      end else begin
        check("mode_stable_in_period", int'(mode), per_mode);
        heat_cnt += int'(heat_out);
        cool_cnt += int'(cool_out);
      end
    end
  end

  // Stimulus and directed checks
  initial begin
    int n;
    enable = 1'b1;
    neg    = 1'b0;
    level  = 8'd64;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_heat_out", int'(heat_out), 0);
    check("reset_cool_out", int'(cool_out), 0);
    check("reset_period_start", int'(period_start), 0);
    check("reset_mode", int'(mode), 0);

    // Period 0 is OFF; level 64 is latched at the first boundary.
    exp_q.push_back(pack(0, 0, 0));
    exp_q.push_back(pack(256, 0, 1));
    rst_n  = 1'b1;
    mon_en = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      wait_ps("table");
      repeat (t_dly[i]) @(negedge clk);
      neg   = t_neg[i][0];
      level = 8'(t_lvl[i]);
      exp_q.push_back(pack(t_heat[i], t_cool[i], t_mode[i]));
    end

    n = 0;
    while (exp_q.size() != 0 && n < 3 * PERIOD) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) timeout_fail("scoreboard_drain");
    #1 mon_en = 1'b0;

    // Disable at phase 30 of a HEAT period at level 128.
    wait_ps("disable_sync");
    repeat (120) @(negedge clk);
    check("heat_before_disable", int'(heat_out), 1);
    enable = 1'b0;
    @(negedge clk);
    check("disable_heat_out", int'(heat_out), 0);
    check("disable_mode", int'(mode), 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_start && n < 2 * PERIOD);
    check("clocks_to_period_start_while_off", n, PERIOD - 121);

    // Enter COOL, then reset mid-period.
    enable = 1'b1;
    neg    = 1'b1;
    wait_ps("cool_entry");
    check("cool_out_before_reset", int'(cool_out), 1);
    check("mode_before_reset", int'(mode), 3);
    repeat (200) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_reset_cool_out", int'(cool_out), 0);
    check("async_reset_heat_out", int'(heat_out), 0);
    check("async_reset_mode", int'(mode), 0);
    check("async_reset_period_start", int'(period_start), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_start && n < 2 * PERIOD);
    check("clocks_to_first_period_start", n, PERIOD);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
